// File: rtl/regfile_dump.sv
// Purpose : streams {index, value} for x0..x(NUM_REGS-1) after a start pulse, forwarding core write-backs.
// Latency : first beat one cycle after start; one beat per cycle with out_ready high; done one cycle after the last beat.
// Backpr. : out_ready low holds out_index/out_valid; out_data only changes through write-back forwarding.
//
// Ports:
//   clk, rst             core clock, synchronous active-low reset
//   start / busy / done  dump request, dump in progress, end-of-dump pulse
//   rf_raddr / rf_rdata  dedicated register-file read port (combinational read)
//   wb_en/wb_addr/wb_data core write-back bus snoop
//   out_valid/out_ready/out_index/out_data  beat stream
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32,
  parameter int IDX_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] rf_raddr,
  input  logic [XLEN-1:0]  rf_rdata,
  input  logic             wb_en,
  input  logic [IDX_W-1:0] wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [XLEN-1:0]  out_data
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REGS - 1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t          state;
  logic [XLEN-1:0] load_val;
  logic            last_beat;

  assign last_beat = (out_index == LAST);

  // Lookahead read: the register after the one being presented, so a
  // handshake can load the next beat in the same edge. Held at the last
  // index to avoid running past the end of the file.
  always_comb begin
    rf_raddr = '0;
    if (state == STREAM) begin
      rf_raddr = last_beat ? out_index : out_index + IDX_W'(1);
    end
  end

  // x0 is hardwired to zero; a write-back in the load cycle beats the
  // register file, which only commits it at this same edge.
  always_comb begin
    load_val = rf_rdata;
    if (rf_raddr == '0) begin
      load_val = '0;
    end else if (wb_en && (wb_addr == rf_raddr)) begin
      load_val = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= STREAM;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_index <= '0;
            out_data  <= '0;
          end
        end
        STREAM: begin
          if (out_valid && out_ready) begin
            if (last_beat) begin
              state     <= IDLE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_index <= out_index + IDX_W'(1);
              out_data  <= load_val;
            end
          end else if (wb_en && (wb_addr == out_index) && (out_index != '0)) begin
            // Stalled beat keeps tracking the latest architectural value.
            out_data <= wb_data;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Hardware register-file dump engine for the single-cycle RISC-V core. On a start pulse it reads every architectural register x0..x(NUM_REGS-1) through a dedicated read port of the register file and streams {index, value} beats out on a valid/ready interface. This provides a synthesizable, on-chip equivalent of the end-of-simulation register listing. It snoops the core's write-back bus so every reported value is the most recent one at the moment of its handshake.

## Interface
- NUM_REGS, 32, number of architectural registers dumped
- XLEN, 32, register data width
- IDX_W, 5, index width, must satisfy 2**IDX_W >= NUM_REGS
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-low: sampled on the rising edge of clk, state cleared when rst==0
- start  in  1  dump request pulse; honoured only in IDLE
- busy  out  1  high while a dump is in progress (state STREAM)
- done  out  1  single-cycle pulse after the last beat is accepted
- rf_raddr  out  IDX_W  register-file read address; the register file returns data combinationally
- rf_rdata  in  XLEN  register-file read data for rf_raddr, same cycle
- wb_en  in  1  core write-back enable (reg_write)
- wb_addr  in  IDX_W  core write-back destination (rd)
- wb_data  in  XLEN  core write-back value
- out_valid  out  1  beat valid
- out_ready  in  1  consumer ready
- out_index  out  IDX_W  register index of current beat
- out_data  out  XLEN  register value of current beat

## Operation
- States: IDLE and STREAM. done is a registered pulse, not a separate state.
- Reset (rst==0 at an edge) sets state=IDLE, out_valid=0, busy=0, done=0, out_index=0, out_data=0. A reset mid-dump aborts it with no done pulse.
- rf_raddr in IDLE is 0. In STREAM it is out_index+1, the lookahead address; when out_index==NUM_REGS-1 it is held at out_index.
- Load value for address a: 0 if a==0; otherwise wb_data if wb_en && wb_addr==a; otherwise rf_rdata.
- IDLE with start=1: load register 0 into out_data, set out_index=0, out_valid=1, go to STREAM.
- STREAM with a handshake (out_valid && out_ready):
  - If out_index<NUM_REGS-1: out_index increments and out_data takes the load value for out_index+1. out_valid stays high, so back-to-back beats are possible.
  - If out_index==NUM_REGS-1: out_valid=0, done=1 for one cycle, go to IDLE.
- STREAM while stalled (out_ready=0): out_index holds. If wb_en && wb_addr==out_index && out_index!=0, out_data is overwritten with wb_data; otherwise out_data holds.
- start is ignored while in STREAM and during the done cycle's edge evaluation. A start arriving in the same cycle that done is asserted is accepted, because the state is already IDLE.
- Writes to x0 never change any reported value. Index arithmetic is unsigned IDX_W bits and never wraps, because the last index is detected explicitly.

## Timing
- start sampled at edge N: out_valid=1 and busy=1 from cycle N+1.
- With out_ready held at 1, beat k is presented in cycle N+1+k. The last beat is accepted at edge N+NUM_REGS, and done=1 with busy=0 in cycle N+NUM_REGS+1.
- Each stall cycle adds exactly one cycle of latency. out_index and out_valid are stable during a stall; out_data changes only through write-back forwarding.
- A write-back in the same cycle as a load for the same address is reflected in the loaded value. A write-back one cycle later is reflected through the stall/forward path, or it lands in the register file before that index is read.

## Test plan
- Preload x1..x31 with value 100+i, start=1 for one cycle, out_ready=1 throughout -> 32 beats in 32 consecutive cycles: index 0 data 0, index 5 data 105, index 31 data 131. done pulses exactly once, in the cycle after beat 31.
- Same preload, out_ready toggling 1,0,1,0... -> 32 beats, each held stable across stall cycles, with total duration 63 cycles from the first valid to done.
- Stall on index 7 (data 107), then drive wb_en=1, wb_addr=7, wb_data=0xDEAD -> out_data becomes 0xDEAD while out_valid stays high and out_index stays 7. A write-back to x0 during the index-0 stall leaves data at 0.
- Drive wb_en=1, wb_addr=12, wb_data=0x55 in the same cycle index 11 is accepted -> beat index 12 carries 0x55.
- Drive rst=0 for one edge while at index 10 -> out_valid=0, busy=0, no done pulse. A following start restarts the dump from index 0.
- Pulse start again at index 3 -> ignored, sequence continues uninterrupted. Assert start in the done cycle -> a new dump begins, with out_valid=1 in the next cycle.
